// File: rtl/rram_inst_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : rram_inst_fifo_if
// Brief    : Push/pop handshake and status bundle for rram_inst_fifo.
// Revision : 1.0 - initial release
// ============================================================================
interface rram_inst_fifo_if #(
    parameter int DATA_WIDTH = 20,
    parameter int DEPTH      = 16
);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic                  push_n;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  full;
    logic                  almost_full;
    logic                  pop_n;
    logic                  empty;
    logic                  almost_empty;
    logic [DATA_WIDTH-1:0] dout;
    logic [c_cnt_w-1:0]    word_count;
    logic                  overflow_err;
    logic                  underflow_err;

    modport master (
        output push_n, data_in, pop_n,
        input  full, almost_full, empty, almost_empty, dout, word_count,
               overflow_err, underflow_err
    );

    modport slave (
        input  push_n, data_in, pop_n,
        output full, almost_full, empty, almost_empty, dout, word_count,
               overflow_err, underflow_err
    );
endinterface
`default_nettype wire

// File: rtl/rram_inst_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rram_inst_fifo
// Brief    : Single-clock FWFT FIFO with occupancy, threshold flags and
//            sticky overflow/underflow errors for the RRAM core queues.
// Revision : 1.0 - initial release
// ============================================================================
module rram_inst_fifo #(
    parameter int DATA_WIDTH = 20,
    parameter int DEPTH      = 16,
    parameter int AE_LEVEL   = 2,
    parameter int AF_LEVEL   = 14
) (
    input  wire logic       CLK,
    input  wire logic       reset,
    rram_inst_fifo_if.slave fifo
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_ae_level = c_cnt_w'(AE_LEVEL);
    localparam logic [c_cnt_w-1:0] c_af_level = c_cnt_w'(AF_LEVEL);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Acceptance uses only registered occupancy, so a pop never frees room
    // for a push in the same cycle (no pass-through when full).
    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);
    assign w_push  = ~fifo.push_n & ~w_full;
    assign w_pop   = ~fifo.pop_n & ~w_empty;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (~fifo.push_n && w_full) begin
                r_overflow <= 1'b1;
            end
            if (~fifo.pop_n && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= fifo.data_in;
        end
    end

    assign fifo.dout          = r_mem[r_rd_ptr];
    assign fifo.full          = w_full;
    assign fifo.empty         = w_empty;
    assign fifo.almost_full   = (r_count >= c_af_level);
    assign fifo.almost_empty  = (r_count <= c_ae_level);
    assign fifo.word_count    = r_count;
    assign fifo.overflow_err  = r_overflow;
    assign fifo.underflow_err = r_underflow;
endmodule
`default_nettype wire

// File: doc/rram_inst_fifo.md
# rram_inst_fifo

Single-clock, first-word-fall-through FIFO that serves the instruction and data queues consumed by the RRAM core controller. The write side is the host or dispatcher port. The read side drives the core's `pop_n` / `empty` / `dout` handshake. One instance is used per queue: instruction ext/hd (20 b) and input data ext/hd (64 b). The FIFO also reports occupancy, threshold flags and sticky protocol errors for debug.

## Interface
Parameters:
- DATA_WIDTH, 20, word width (INSTR_WIDTH+OPCODE_WIDTH); set to 64 for data queues
- DEPTH, 16, number of entries; power of two, ≥2
- AE_LEVEL, 2, almost_empty asserted when count ≤ AE_LEVEL
- AF_LEVEL, 14, almost_full asserted when count ≥ AF_LEVEL

Ports:
- CLK  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- push_n  in  1  active-low write request (host side)
- data_in  in  DATA_WIDTH  write word
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AF_LEVEL
- pop_n  in  1  active-low read request (core side)
- empty  out  1  count == 0
- almost_empty  out  1  count ≤ AE_LEVEL
- dout  out  DATA_WIDTH  head word, valid whenever empty==0
- word_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow_err  out  1  sticky; set on push_n=0 while full
- underflow_err  out  1  sticky; set on pop_n=0 while empty

## Operation
- Storage is a DEPTH×DATA_WIDTH register array with write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits. Pointers wrap modulo DEPTH naturally. Occupancy is tracked in a separate count register.
- Accepted push: push_n==0 && full==0. Effects: mem[wr_ptr] ← data_in, wr_ptr+1.
- Accepted pop: pop_n==0 && empty==0. Effect: rd_ptr+1.
- Count update:
  - push only: +1
  - pop only: −1
  - both accepted: unchanged (simultaneous read/write of different slots; at count 0 or DEPTH only one side can be accepted)
- Push while full: no write, no pointer change. overflow_err ← 1.
- Pop while empty: no change. underflow_err ← 1. A push in the same cycle is still accepted.
- Push while full with a simultaneous pop: the pop is accepted and the push is rejected with overflow_err ← 1. There is no pass-through.
- dout is always mem[rd_ptr] (FWFT). Its value while empty==1 is don't-care; the bench must not check it.
- Errors stay set until reset. There is no other clear.
- All flags and word_count are decoded from the count register, so they are registered values with no combinational path from push_n or pop_n.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0 (given AF_LEVEL>0), word_count=0, overflow_err=0, underflow_err=0. Memory contents are not reset.

## Timing
- Write-to-read latency is 1 cycle. For a word pushed at edge k into an empty FIFO, empty falls and dout shows the word after edge k, so the core may pop at edge k+1.
- Pop: after edge k, dout shows the next entry, or empty rises if the popped entry was the last.
- Flags change only on CLK edges, or asynchronously on reset assertion.
- Reset asserted mid-operation clears all state immediately. The first push is accepted at the first rising edge where reset is low.
- Throughput is one push and one pop per cycle, sustained.

## Test plan
- Reset check: assert reset, then release. Required: empty=1, almost_empty=1, full=0, almost_full=0, word_count=0, both errors 0. The push of 0x12345 at the next edge gives empty=0 and dout=0x12345 one cycle later.
- Fill/overflow: push 0x00001..0x00010 (16 words).
  - almost_full rises when word_count=14.
  - full=1 at word_count=16.
  - A 17th push of 0xFFFFF sets overflow_err=1, leaves word_count=16, and does not appear later.
- Drain/underflow: pop 16 times from the fill test. Required: dout sequence 0x00001..0x00010 in order, almost_empty=1 from word_count=2, empty=1 after the last pop. An extra pop sets underflow_err=1 and leaves word_count=0.
- Simultaneous push+pop:
  - At word_count=5, hold push_n=0 and pop_n=0 for 40 cycles with incrementing data. Required: word_count stays 5, ordering is preserved, pointers wrap past 15 without loss, no errors.
- Empty-edge race: at empty, push 0xAAAAA and pop in the same cycle. Required: push accepted, underflow_err=1, word_count=1, dout=0xAAAAA.
- Reset mid-operation: at word_count=9, assert reset for one cycle between edges. Required: all outputs return to reset values immediately, errors cleared, next push/pop sequence behaves as from power-up.
